// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the five pipeline registers of the 5-stage pipeline.
// Handles boot hold-off, hazard priority, halt drain and saturating perf counters.
module pipe_stall_ctrl #(
    parameter int BOOT_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             halt_req,
    output logic             pc_load,
    output logic             ifid_load,
    output logic             idex_load,
    output logic             exmem_load,
    output logic             memwb_load,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int BOOT_W  = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES + 1) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [BOOT_W-1:0]  BOOT_LAST  = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t             r_state;
    logic [BOOT_W-1:0]  r_boot_cnt;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic               r_halted;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic w_pc_load;
    logic w_ifid_load;
    logic w_idex_load;
    logic w_exmem_load;
    logic w_memwb_load;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_stall_evt;
    logic w_flush_evt;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        w_pc_load    = 1'b0;
        w_ifid_load  = 1'b0;
        w_idex_load  = 1'b0;
        w_exmem_load = 1'b0;
        w_memwb_load = 1'b0;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (dcache_stall) begin
                    // full freeze: defaults already hold every register
                end else if (icache_stall || load_use) begin
                    // front end holds, a bubble enters EX, back end keeps draining
                    w_idex_load  = 1'b1;
                    w_idex_flush = 1'b1;
                    w_exmem_load = 1'b1;
                    w_memwb_load = 1'b1;
                end else begin
                    w_pc_load    = 1'b1;
                    w_ifid_load  = 1'b1;
                    w_idex_load  = 1'b1;
                    w_exmem_load = 1'b1;
                    w_memwb_load = 1'b1;
                    w_ifid_flush = branch_taken;
                end
            end
            ST_DRAIN: begin
                if (!dcache_stall) begin
                    w_ifid_load  = 1'b1;
                    w_ifid_flush = 1'b1;
                    w_idex_load  = 1'b1;
                    w_exmem_load = 1'b1;
                    w_memwb_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign w_stall_evt = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && !w_pc_load;
    assign w_flush_evt = (w_ifid_load && w_ifid_flush) || (w_idex_load && w_idex_flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_BOOT;
            r_boot_cnt  <= '0;
            r_drain_cnt <= DRAIN_INIT;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                ST_BOOT: begin
                    if (r_boot_cnt == BOOT_LAST) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_boot_cnt <= r_boot_cnt + BOOT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (halt_req && !dcache_stall) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!dcache_stall) begin
                        r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                        if (r_drain_cnt == DRAIN_W'(1)) begin
                            r_state  <= ST_HALTED;
                            r_halted <= 1'b1;
                        end
                    end
                end
                ST_HALTED: ;
                default: r_state <= ST_BOOT;
            endcase

            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_load    = w_pc_load;
    assign ifid_load  = w_ifid_load;
    assign idex_load  = w_idex_load;
    assign exmem_load = w_exmem_load;
    assign memwb_load = w_memwb_load;
    assign ifid_flush = w_ifid_flush;
    assign idex_flush = w_idex_flush;
    assign halted     = r_halted;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: vector table for RUN priority plus
// hand-written boot, drain, saturation and reset sequences.
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst_n;
    logic        icache_stall;
    logic        dcache_stall;
    logic        load_use;
    logic        branch_taken;
    logic        halt_req;
    logic        pc_load;
    logic        ifid_load;
    logic        idex_load;
    logic        exmem_load;
    logic        memwb_load;
    logic        ifid_flush;
    logic        idex_flush;
    logic        halted;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int          total;
    int          bad;
    logic [31:0] e_stall;
    logic [31:0] e_flush;

    pipe_stall_ctrl #(
        .BOOT_CYCLES  (2),
        .DRAIN_CYCLES (4),
        .CNT_W        (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .icache_stall (icache_stall),
        .dcache_stall (dcache_stall),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .halt_req     (halt_req),
        .pc_load      (pc_load),
        .ifid_load    (ifid_load),
        .idex_load    (idex_load),
        .exmem_load   (exmem_load),
        .memwb_load   (memwb_load),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bit order: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    typedef struct {
        string      name;
        logic       ic;
        logic       dc;
        logic       lu;
        logic       br;
        logic [6:0] exp_outs;
        logic       st_inc;
        logic       fl_inc;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [6:0] exp7, input logic exp_h);
        check(name, {24'd0, pc_load, ifid_load, idex_load, exmem_load, memwb_load,
                     ifid_flush, idex_flush, halted},
              {24'd0, exp7, exp_h});
    endtask

    task automatic chk_cnt(input string name);
        check({name, "_stall"}, stall_cnt, e_stall);
        check({name, "_flush"}, flush_cnt, e_flush);
    endtask

    task automatic set_in(input logic ic, input logic dc, input logic lu,
                          input logic br, input logic hr);
        icache_stall = ic;
        dcache_stall = dc;
        load_use     = lu;
        branch_taken = br;
        halt_req     = hr;
    endtask

    // One cycle: drive inputs after the falling edge, check, run through the next rising edge.
    task automatic cyc(input string name, input logic ic, input logic dc, input logic lu,
                       input logic br, input logic hr, input logic [6:0] exp7, input logic exp_h);
        set_in(ic, dc, lu, br, hr);
        #1;
        chk_outs(name, exp7, exp_h);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total   = 0;
        bad     = 0;
        e_stall = 32'd0;
        e_flush = 32'd0;
        rst_n   = 1'b0;
        set_in(0, 0, 0, 0, 0);

        vecs[0] = '{"v_idle",     0, 0, 0, 0, 7'b1111100, 0, 0};
        vecs[1] = '{"v_branch",   0, 0, 0, 1, 7'b1111110, 0, 1};
        vecs[2] = '{"v_icache",   1, 0, 0, 0, 7'b0011101, 1, 1};
        vecs[3] = '{"v_loaduse",  0, 0, 1, 0, 7'b0011101, 1, 1};
        vecs[4] = '{"v_dcache",   0, 1, 0, 0, 7'b0000000, 1, 0};
        vecs[5] = '{"v_ic_br",    1, 0, 0, 1, 7'b0011101, 1, 1};
        vecs[6] = '{"v_lu_br",    0, 0, 1, 1, 7'b0011101, 1, 1};
        vecs[7] = '{"v_all",      1, 1, 1, 1, 7'b0000000, 1, 0};
        vecs[8] = '{"v_ic_dc",    1, 1, 0, 0, 7'b0000000, 1, 0};
        vecs[9] = '{"v_branch2",  0, 0, 0, 1, 7'b1111110, 0, 1};

        #12;
        chk_outs("reset", 7'b0000000, 1'b0);
        chk_cnt("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Boot: two cycles with every load low, then normal operation
        cyc("boot0", 0, 0, 0, 0, 0, 7'b0000000, 0);
        cyc("boot1", 0, 0, 0, 0, 0, 7'b0000000, 0);
        cyc("run0",  0, 0, 0, 0, 0, 7'b1111100, 0);
        chk_cnt("boot");

        // Single load-use bubble
        cyc("lu1",    0, 0, 1, 0, 0, 7'b0011101, 0);
        e_stall = 32'd1;
        e_flush = 32'd1;
        chk_cnt("lu1");

        // Branch held under dcache freeze, honoured on first unblocked cycle
        for (int i = 0; i < 3; i++) begin
            cyc("dc_br", 0, 1, 0, 1, 0, 7'b0000000, 0);
        end
        cyc("br_after", 0, 0, 0, 1, 0, 7'b1111110, 0);
        e_stall = 32'd4;
        e_flush = 32'd2;
        chk_cnt("dc_br");

        // icache and load-use together
        for (int i = 0; i < 2; i++) begin
            cyc("ic_lu", 1, 0, 1, 0, 0, 7'b0011101, 0);
        end
        e_stall = 32'd6;
        e_flush = 32'd4;
        chk_cnt("ic_lu");

        for (int i = 0; i < 10; i++) begin
            cyc(vecs[i].name, vecs[i].ic, vecs[i].dc, vecs[i].lu, vecs[i].br, 0,
                vecs[i].exp_outs, 0);
            e_stall = e_stall + 32'(vecs[i].st_inc);
            e_flush = e_flush + 32'(vecs[i].fl_inc);
            chk_cnt(vecs[i].name);
        end

        // Saturation of the stall counter
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        for (int i = 0; i < 3; i++) begin
            cyc("sat_lu", 0, 0, 1, 0, 0, 7'b0011101, 0);
            e_flush = e_flush + 32'd1;
            check("sat_stall", stall_cnt, 32'hFFFF_FFFF);
            check("sat_flush", flush_cnt, e_flush);
        end

        // Asynchronous reset in the middle of a normal cycle
        set_in(0, 0, 0, 0, 0);
        #1;
        chk_outs("pre_rst", 7'b1111100, 0);
        #1;
        rst_n = 1'b0;
        #1;
        e_stall = 32'd0;
        e_flush = 32'd0;
        chk_outs("rst_mid", 7'b0000000, 0);
        chk_cnt("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;

        // Reboot with hazard inputs active: they must be ignored
        cyc("reboot0", 1, 0, 1, 1, 0, 7'b0000000, 0);
        cyc("reboot1", 1, 0, 1, 1, 0, 7'b0000000, 0);
        chk_cnt("reboot");

        // Halt deferred by dcache, then taken
        cyc("halt_dc", 0, 1, 0, 0, 1, 7'b0000000, 0);
        cyc("halt_go", 0, 0, 0, 0, 1, 7'b1111100, 0);
        e_stall = 32'd1;
        chk_cnt("halt_go");

        // Drain: 4 advancing cycles plus 1 frozen; halt_req drops and hazards are ignored
        cyc("drain1",    0, 0, 0, 0, 0, 7'b0111110, 0);
        cyc("drain2_dc", 0, 1, 0, 0, 0, 7'b0000000, 0);
        cyc("drain3",    1, 0, 1, 1, 0, 7'b0111110, 0);
        cyc("drain4",    0, 0, 0, 0, 0, 7'b0111110, 0);
        cyc("drain5",    0, 0, 0, 0, 1, 7'b0111110, 0);
        e_stall = e_stall + 32'd5;
        e_flush = e_flush + 32'd4;
        chk_cnt("drain");

        cyc("halted0", 1, 0, 1, 1, 1, 7'b0000000, 1);
        cyc("halted1", 0, 0, 0, 0, 0, 7'b0000000, 1);
        chk_cnt("halted");

        // Reset leaves HALTED immediately
        #1;
        rst_n = 1'b0;
        #1;
        chk_outs("rst_halted", 7'b0000000, 0);
        e_stall = 32'd0;
        e_flush = 32'd0;
        chk_cnt("rst_halted");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
